// File: rtl/pattern_pkg.sv
// Shared types and range limits for the serial pattern link transmitter.
// Optional feature macro: PATTERN_SERIALIZER_PARITY_EN (appends an even-parity bit).
package pattern_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;
    localparam int MAX_GAP   = 15;
    localparam int GAP_W     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        GAP   = 3'b100
    } ser_state_t;

endpackage

// File: rtl/pattern_serializer_if.sv
// Word handshake in, serial frame out; the controller side is the master.
// Optional feature macro: PATTERN_SERIALIZER_PARITY_EN (no effect on the signal set).
interface pattern_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             data_ready;
    logic             serial_pattern;
    logic             enable;
    logic             frame_done;

    modport master (
        output data, data_valid,
        input  data_ready, serial_pattern, enable, frame_done
    );

    modport slave (
        input  data, data_valid,
        output data_ready, serial_pattern, enable, frame_done
    );
endinterface

// File: rtl/pattern_piso.sv
// Parallel-in/serial-out register; head is the bit currently on the wire.
// Optional feature macro: PATTERN_SERIALIZER_PARITY_EN (not referenced here).
module pattern_piso
    import pattern_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             head
);
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;

    // Zeros shift in behind the frame so the line idles low once it drains.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {sr[WIDTH-2:0], 1'b0};
            assign head    = sr[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {1'b0, sr[WIDTH-1:1]};
            assign head    = sr[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstb)      sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= shifted;
    end
endmodule

// File: rtl/pattern_serializer.sv
// Transmit end of the serial pattern link: word handshake in, framed bit stream out.
// Optional feature macro: PATTERN_SERIALIZER_PARITY_EN (even-parity bit after the data bits).
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                clk,
    input  logic                rstb,
    pattern_serializer_if.slave bus
);
    localparam int CW       = $clog2(WIDTH + 2);
    localparam int HEAD_POS = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || GAP_CYCLES < 0 || GAP_CYCLES > MAX_GAP) begin : g_bad_cfg
            $error("pattern_serializer: WIDTH or GAP_CYCLES out of range");
        end
    endgenerate

    ser_state_t       state;
    logic [CW-1:0]    bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             enable;
    logic             frame_done;
    logic             load;
    logic             shift;
    logic             head;
    logic [WIDTH-1:0] load_word;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    logic             parity;
`endif

    // bit_cnt counts frame bits still on the wire, including the one shown now.
    always_comb begin
        load      = 1'b0;
        shift     = 1'b0;
        load_word = bus.data;
        case (state)
            IDLE:  load = bus.data_valid;
            SHIFT: begin
`ifdef PATTERN_SERIALIZER_PARITY_EN
                // Parity rides the load path so it lands directly on the head bit.
                if (bit_cnt == CW'(2)) begin
                    load                = 1'b1;
                    load_word           = '0;
                    load_word[HEAD_POS] = parity;
                end else begin
                    shift = 1'b1;
                end
`else
                shift = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    pattern_piso #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso (
        .clk   (clk),
        .rstb  (rstb),
        .load  (load),
        .shift (shift),
        .din   (load_word),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            enable     <= 1'b0;
            frame_done <= 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    enable     <= bus.data_valid;
                    if (bus.data_valid) begin
                        state   <= SHIFT;
                        bit_cnt <= CW'(FRAME_BITS);
`ifdef PATTERN_SERIALIZER_PARITY_EN
                        parity  <= ^bus.data;
`endif
                    end
                end
                SHIFT: begin
                    bit_cnt    <= bit_cnt - CW'(1);
                    frame_done <= (bit_cnt == CW'(2));
                    if (bit_cnt == CW'(1)) begin
                        enable <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_CYCLES);
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_ready     = (state == IDLE);
    assign bus.serial_pattern = head;
    assign bus.enable         = enable;
    assign bus.frame_done     = frame_done;
endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: three instances cover MSB/LSB order and gap lengths.
// Optional feature macro: PATTERN_SERIALIZER_PARITY_EN (adds the parity-bit scenario).
module tb_pattern_serializer;
    localparam int W = 8;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F = W + PB;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pattern_serializer_if #(.WIDTH(W)) bus_a ();
    pattern_serializer_if #(.WIDTH(W)) bus_b ();
    pattern_serializer_if #(.WIDTH(W)) bus_c ();

    pattern_serializer #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1)) u_a (.clk(clk), .rstb(rstb), .bus(bus_a));
    pattern_serializer #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(0)) u_b (.clk(clk), .rstb(rstb), .bus(bus_b));
    pattern_serializer #(.WIDTH(W), .GAP_CYCLES(2), .MSB_FIRST(1)) u_c (.clk(clk), .rstb(rstb), .bus(bus_c));

    // Observed vector per instance: {ready, enable, serial, frame_done}.
    logic [3:0] obs_a, obs_b, obs_c;
    assign obs_a = {bus_a.data_ready, bus_a.enable, bus_a.serial_pattern, bus_a.frame_done};
    assign obs_b = {bus_b.data_ready, bus_b.enable, bus_b.serial_pattern, bus_b.frame_done};
    assign obs_c = {bus_c.data_ready, bus_c.enable, bus_c.serial_pattern, bus_c.frame_done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit k of a frame in wire order; index W is the even-parity bit.
    function automatic logic exp_bit(logic [W-1:0] w, bit msb, int k);
        if (k >= W) return ^w;
        return msb ? w[W-1-k] : w[k];
    endfunction

    task automatic test_reset();
        rstb = 1'b0;
        step();
        step();
        checks++;
        if (obs_a !== 4'b1000) begin
            failures++;
            $display("FAIL reset_a got=%b exp=1000", obs_a);
        end
        checks++;
        if (obs_b !== 4'b1000) begin
            failures++;
            $display("FAIL reset_b got=%b exp=1000", obs_b);
        end
        checks++;
        if (obs_c !== 4'b1000) begin
            failures++;
            $display("FAIL reset_c got=%b exp=1000", obs_c);
        end
        rstb = 1'b1;
        step();
    endtask

    task automatic test_msb_first();
        logic [3:0] e;
        bus_a.data = 8'hB4;
        bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        bus_a.data = 8'hFF;
        for (int k = 0; k < F; k++) begin
            e = {1'b0, 1'b1, exp_bit(8'hB4, 1'b1, k), (k == F - 1)};
            checks++;
            if (obs_a !== e) begin
                failures++;
                $display("FAIL msb_bit%0d got=%b exp=%b", k, obs_a, e);
            end
            step();
        end
        checks++;
        if (obs_a !== 4'b0000) begin
            failures++;
            $display("FAIL msb_gap got=%b exp=0000", obs_a);
        end
        step();
        checks++;
        if (obs_a !== 4'b1000) begin
            failures++;
            $display("FAIL msb_ready_again got=%b exp=1000", obs_a);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] e;
        bus_b.data = 8'h01;
        bus_b.data_valid = 1'b1;
        step();
        bus_b.data_valid = 1'b0;
        for (int k = 0; k < F; k++) begin
            e = {1'b0, 1'b1, (k == 0) || (k == W), (k == F - 1)};
            checks++;
            if (obs_b !== e) begin
                failures++;
                $display("FAIL lsb_bit%0d got=%b exp=%b", k, obs_b, e);
            end
            step();
        end
        checks++;
        if (obs_b !== 4'b0000) begin
            failures++;
            $display("FAIL lsb_gap got=%b exp=0000", obs_b);
        end
        step();
        checks++;
        if (obs_b !== 4'b1000) begin
            failures++;
            $display("FAIL lsb_ready_again got=%b exp=1000", obs_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        bus_c.data = 8'hFF;
        bus_c.data_valid = 1'b1;
        step();
        bus_c.data = 8'h00;
        for (int k = 0; k < F; k++) begin
            e = {1'b0, 1'b1, exp_bit(8'hFF, 1'b1, k), (k == F - 1)};
            checks++;
            if (obs_c !== e) begin
                failures++;
                $display("FAIL b2b_w0_bit%0d got=%b exp=%b", k, obs_c, e);
            end
            step();
        end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (obs_c !== 4'b0000) begin
                failures++;
                $display("FAIL b2b_gap%0d got=%b exp=0000", g, obs_c);
            end
            step();
        end
        // Valid has stayed high: the first IDLE cycle must take the second word.
        checks++;
        if (obs_c !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_idle got=%b exp=1000", obs_c);
        end
        step();
        for (int k = 0; k < F; k++) begin
            e = {1'b0, 1'b1, exp_bit(8'h00, 1'b1, k), (k == F - 1)};
            checks++;
            if (obs_c !== e) begin
                failures++;
                $display("FAIL b2b_w1_bit%0d got=%b exp=%b", k, obs_c, e);
            end
            step();
        end
        bus_c.data_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (obs_c !== 4'b0000) begin
                failures++;
                $display("FAIL b2b_tail_gap%0d got=%b exp=0000", g, obs_c);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_c !== 4'b1000) begin
                failures++;
                $display("FAIL b2b_no_dup%0d got=%b exp=1000", i, obs_c);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] e;
        bus_a.data = 8'hAA;
        bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = {1'b0, 1'b1, exp_bit(8'hAA, 1'b1, k), 1'b0};
            checks++;
            if (obs_a !== e) begin
                failures++;
                $display("FAIL rst_mid_bit%0d got=%b exp=%b", k, obs_a, e);
            end
            if (k == 3) rstb = 1'b0;
            step();
        end
        rstb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_a !== 4'b1000) begin
                failures++;
                $display("FAIL rst_mid_idle%0d got=%b exp=1000", i, obs_a);
            end
            step();
        end
        bus_a.data = 8'hC3;
        bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < F; k++) begin
            e = {1'b0, 1'b1, exp_bit(8'hC3, 1'b1, k), (k == F - 1)};
            checks++;
            if (obs_a !== e) begin
                failures++;
                $display("FAIL rst_recover_bit%0d got=%b exp=%b", k, obs_a, e);
            end
            step();
        end
        step();
        checks++;
        if (obs_a !== 4'b1000) begin
            failures++;
            $display("FAIL rst_recover_ready got=%b exp=1000", obs_a);
        end
    endtask

`ifdef PATTERN_SERIALIZER_PARITY_EN
    task automatic test_parity();
        bus_a.data = 8'hB5;
        bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < W; k++) step();
        checks++;
        if (obs_a !== 4'b0111) begin
            failures++;
            $display("FAIL parity_b5 got=%b exp=0111", obs_a);
        end
        step();
        step();
    endtask
`endif

    task automatic test_loopback();
        logic [2:0] hist;
        logic       det;
        logic [7:0] det_exp;
        det_exp = 8'b0111_1100;
        hist = 3'b000;
        bus_a.data = 8'b0110_1100;
        bus_a.data_valid = 1'b1;
        step();
        bus_a.data_valid = 1'b0;
        for (int k = 0; k < F; k++) begin
            hist = bus_a.enable ? {hist[1:0], bus_a.serial_pattern} : 3'b000;
            det = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
            if (k < W) begin
                checks++;
                if (det !== det_exp[k]) begin
                    failures++;
                    $display("FAIL loop_det%0d got=%b exp=%b", k, det, det_exp[k]);
                end
            end
            step();
        end
        checks++;
        if (bus_a.enable !== 1'b0) begin
            failures++;
            $display("FAIL loop_gap_clear got=%b exp=0", bus_a.enable);
        end
        step();
        step();
    endtask

    initial begin
        bus_a.data = '0;
        bus_a.data_valid = 1'b0;
        bus_b.data = '0;
        bus_b.data_valid = 1'b0;
        bus_c.data = '0;
        bus_c.data_valid = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PATTERN_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Transmit end of the serial pattern link. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on serial_pattern_o.
- Drives enable_o as the frame qualifier consumed by the pattern detector. Enable low resets the detector, so frames are separated by enable-low gap cycles.
- Sits between the test/stimulus controller and the detector input.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- GAP_CYCLES, 1, enable-low idle cycles after each frame; legal range 0..15.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rstb  input  1  synchronous reset, active low.
- data_i  input  WIDTH  parallel word to transmit.
- data_valid_i  input  1  data_i is valid.
- data_ready_o  output  1  block can accept a word this cycle.
- serial_pattern_o  output  1  serial bit stream; registered.
- enable_o  output  1  high while serial_pattern_o carries a frame bit; registered.
- frame_done_o  output  1  one-cycle pulse coincident with the last bit of a frame; registered.

Behaviour:
- Reset, taken at a rising edge with rstb=0:
  - state=IDLE, shift register=0, counters=0.
  - serial_pattern_o=0, enable_o=0, frame_done_o=0.
  - data_ready_o=1, decoded from state==IDLE.
- States, one-hot: IDLE, SHIFT, GAP.
- IDLE:
  - data_ready_o=1; enable_o=0; serial_pattern_o=0.
  - Handshake at edge N (data_valid_i & data_ready_o): capture data_i into the shift register, load bit counter = WIDTH, go to SHIFT.
- SHIFT:
  - Cycles N+1 .. N+WIDTH: enable_o=1; serial_pattern_o = current head bit (MSB or LSB per MSB_FIRST).
  - Shift register shifts one place per cycle; counter decrements per cycle.
  - data_ready_o=0; data_i and data_valid_i are ignored.
  - frame_done_o=1 on cycle N+WIDTH only.
  - After the last bit: go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - enable_o=0; serial_pattern_o=0; data_ready_o=0.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
- Latency: first bit appears one cycle after the handshake.
- Throughput: one word per WIDTH+GAP_CYCLES+1 cycles, counting the IDLE accept cycle.
- No word is accepted during SHIFT or GAP. data_valid_i held high is accepted on the first IDLE cycle.
- Reset mid-frame: the frame is dropped with no frame_done_o pulse. Outputs read the reset values from the next cycle.
- Width rules:
  - Bit counter width = $clog2(WIDTH+2).
  - Gap counter width = 4 bits.
  - Counters never wrap; terminal-count compares are exact.
- Outputs never glitch: serial_pattern_o, enable_o and frame_done_o come straight from flops.

Optional Feature:
- Macro: PATTERN_SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits) is sent immediately after the last data bit, with enable_o still high.
  - The frame is WIDTH+1 bits; frame_done_o moves to the parity cycle.
  - Throughput: one word per WIDTH+GAP_CYCLES+2 cycles.
- Not defined: frames are WIDTH bits, exactly as described above.

Decomposition:
- Shared package pattern_pkg holds:
  - typedef enum logic [2:0] ser_state_t {IDLE, SHIFT, GAP}, one-hot encoded.
  - Localparams for the maximum WIDTH and GAP_CYCLES range checks.
- One natural sub-module: pattern_piso. It is the parallel-in/serial-out shift register with load, shift and MSB_FIRST select, and exposes its head bit.
- The FSM and counters stay in the top level.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=1, data_i=8'hB4 accepted at edge N -> serial 1,0,1,1,0,1,0,0 on N+1..N+8; enable_o high exactly 8 cycles; frame_done_o at N+8; data_ready_o high again at N+10.
- MSB_FIRST=0, data_i=8'h01 -> serial 1 then seven 0s; enable_o high 8 cycles.
- GAP=2, data_valid_i held high with words 8'hFF then 8'h00 -> exactly 2 enable-low cycles between frames; second word accepted on first IDLE cycle; no word lost or duplicated.
- rstb driven low during the 4th bit of 8'hAA -> next cycle enable_o=0, serial=0, frame_done_o never pulses, data_ready_o=1; a new word sends cleanly afterwards.
- PARITY_EN defined, 8'hB4 -> 9th bit 0 at N+9 with frame_done_o at N+9; 8'hB5 -> 9th bit 1.
- Loopback to the detector, data 8'b0110_1100 MSB first -> detector output matches the 2-of-3-ones reference model per bit; detector is cleared during the gap.
